sal_cmd_sched: RTL and testbench

Command-bus scheduler for the DDR controller. It sits between the per-bank controllers (SCHED_IF sources) and the DFI command issue stage. Each cycle it grants at most one ACT/RD/WR/PRE/REF request, enforcing the inter-bank timing constraints tRRD, tCCD, tWTR and tRTW, and it registers the winning command for issue.

---
 rtl/sal_cmd_sched.sv | 178 +++++++++++++++++
 tb/tb_sal_cmd_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_cmd_sched.sv
// Command-bus scheduler: grants one REF/RD/WR/ACT/PRE per cycle under tRRD/tCCD/tWTR/tRTW.
// Optional SCHED_RW_AFFINITY_EN: column arbitration prefers the last column direction.
module sal_cmd_sched #(
    parameter int NUM_BANKS = 4,
    parameter int BA_WIDTH  = 2,
    parameter int RA_WIDTH  = 16,
    parameter int CA_WIDTH  = 10,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 4,
    parameter int TW        = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [TW-1:0]                  t_rrd_m1,
    input  logic [TW-1:0]                  t_ccd_m1,
    input  logic [TW-1:0]                  t_wtr_m1,
    input  logic [TW-1:0]                  t_rtw_m1,
    input  logic [NUM_BANKS-1:0]           act_req,
    input  logic [NUM_BANKS-1:0]           rd_req,
    input  logic [NUM_BANKS-1:0]           wr_req,
    input  logic [NUM_BANKS-1:0]           pre_req,
    input  logic                           ref_req,
    input  logic [NUM_BANKS*RA_WIDTH-1:0]  bk_ra,
    input  logic [NUM_BANKS*CA_WIDTH-1:0]  bk_ca,
    input  logic [NUM_BANKS*ID_WIDTH-1:0]  bk_id,
    input  logic [NUM_BANKS*LEN_WIDTH-1:0] bk_len,
    output logic [NUM_BANKS-1:0]           act_gnt,
    output logic [NUM_BANKS-1:0]           rd_gnt,
    output logic [NUM_BANKS-1:0]           wr_gnt,
    output logic [NUM_BANKS-1:0]           pre_gnt,
    output logic                           ref_gnt,
    output logic                           cmd_valid,
    output logic [2:0]                     cmd_type,
    output logic [BA_WIDTH-1:0]            cmd_ba,
    output logic [RA_WIDTH-1:0]            cmd_ra,
    output logic [CA_WIDTH-1:0]            cmd_ca,
    output logic [ID_WIDTH-1:0]            cmd_id,
    output logic [LEN_WIDTH-1:0]           cmd_len
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    logic [TW-1:0]       rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
    logic [BA_WIDTH-1:0] col_ptr, act_ptr, pre_ptr;
    logic                last_col_wr;

    // Round-robin search starting at ptr; index wraps by truncation (NUM_BANKS is a power of 2).
    function automatic logic [BA_WIDTH:0] rr_pick(input logic [NUM_BANKS-1:0] mask,
                                                  input logic [BA_WIDTH-1:0] ptr);
        logic                found;
        logic [BA_WIDTH-1:0] idx;
        logic [BA_WIDTH-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            idx = ptr + BA_WIDTH'(i);
            if (!found && mask[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    logic [NUM_BANKS-1:0] col_rd_ok, col_wr_ok, col_mask;
    logic                 col_found, act_found, pre_found;
    logic [BA_WIDTH-1:0]  col_win, act_win, pre_win;

    // A bank asserting both RD and WR is treated as RD only.
    assign col_rd_ok = rd_req & {NUM_BANKS{(ccd_cnt == '0) && (wtr_cnt == '0)}};
    assign col_wr_ok = wr_req & ~rd_req & {NUM_BANKS{(ccd_cnt == '0) && (rtw_cnt == '0)}};

`ifdef SCHED_RW_AFFINITY_EN
    logic [NUM_BANKS-1:0] col_pref;
    assign col_pref = last_col_wr ? col_wr_ok : col_rd_ok;
    assign col_mask = (|col_pref) ? col_pref : (col_rd_ok | col_wr_ok);
`else
    assign col_mask = col_rd_ok | col_wr_ok;
`endif

    assign {col_found, col_win} = rr_pick(col_mask, col_ptr);
    assign {act_found, act_win} = rr_pick(act_req & {NUM_BANKS{rrd_cnt == '0}}, act_ptr);
    assign {pre_found, pre_win} = rr_pick(pre_req, pre_ptr);

    logic [2:0]          sel_type;
    logic [BA_WIDTH-1:0] sel_bank;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        act_gnt  = '0;
        rd_gnt   = '0;
        wr_gnt   = '0;
        pre_gnt  = '0;
        ref_gnt  = 1'b0;
        sel_type = CMD_NOP;
        sel_bank = '0;
        if (ref_req) begin
            ref_gnt  = 1'b1;
            sel_type = CMD_REF;
        end else if (col_found) begin
            sel_bank = col_win;
            if (rd_req[col_win]) begin
                rd_gnt[col_win] = 1'b1;
                sel_type        = CMD_RD;
            end else begin
                wr_gnt[col_win] = 1'b1;
                sel_type        = CMD_WR;
            end
        end else if (act_found) begin
            sel_bank         = act_win;
            act_gnt[act_win] = 1'b1;
            sel_type         = CMD_ACT;
        end else if (pre_found) begin
            sel_bank         = pre_win;
            pre_gnt[pre_win] = 1'b1;
            sel_type         = CMD_PRE;
        end
    end

    logic is_act, is_rd, is_wr, is_pre, is_bank_cmd;
    assign is_act      = (sel_type == CMD_ACT);
    assign is_rd       = (sel_type == CMD_RD);
    assign is_wr       = (sel_type == CMD_WR);
    assign is_pre      = (sel_type == CMD_PRE);
    assign is_bank_cmd = is_act | is_rd | is_wr | is_pre;

    // A grant load takes precedence over the saturating decrement.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt     <= '0;
            ccd_cnt     <= '0;
            wtr_cnt     <= '0;
            rtw_cnt     <= '0;
            col_ptr     <= '0;
            act_ptr     <= '0;
            pre_ptr     <= '0;
            last_col_wr <= 1'b0;
        end else begin
            rrd_cnt <= is_act ? t_rrd_m1 : ((rrd_cnt != '0) ? rrd_cnt - TW'(1) : rrd_cnt);
            ccd_cnt <= (is_rd || is_wr) ? t_ccd_m1 : ((ccd_cnt != '0) ? ccd_cnt - TW'(1) : ccd_cnt);
            wtr_cnt <= is_wr ? t_wtr_m1 : ((wtr_cnt != '0) ? wtr_cnt - TW'(1) : wtr_cnt);
            rtw_cnt <= is_rd ? t_rtw_m1 : ((rtw_cnt != '0) ? rtw_cnt - TW'(1) : rtw_cnt);
            if (is_rd || is_wr) col_ptr <= sel_bank + BA_WIDTH'(1);
            if (is_act)         act_ptr <= sel_bank + BA_WIDTH'(1);
            if (is_pre)         pre_ptr <= sel_bank + BA_WIDTH'(1);
            last_col_wr <= is_wr | (last_col_wr & ~is_rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NOP;
            cmd_ba    <= '0;
            cmd_ra    <= '0;
            cmd_ca    <= '0;
            cmd_id    <= '0;
            cmd_len   <= '0;
        end else begin
            cmd_valid <= (sel_type != CMD_NOP);
            cmd_type  <= sel_type;
            if (is_bank_cmd) begin
                cmd_ba  <= sel_bank;
                cmd_ra  <= bk_ra[sel_bank*RA_WIDTH +: RA_WIDTH];
                cmd_ca  <= bk_ca[sel_bank*CA_WIDTH +: CA_WIDTH];
                cmd_id  <= bk_id[sel_bank*ID_WIDTH +: ID_WIDTH];
                cmd_len <= bk_len[sel_bank*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Directed scoreboard bench for sal_cmd_sched: expected grants per cycle, expected
// registered command queued and compared one cycle later.
module tb_sal_cmd_sched;

    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
    logic [NB-1:0]   act_req, rd_req, wr_req, pre_req;
    logic            ref_req;
    logic [NB*16-1:0] bk_ra;
    logic [NB*10-1:0] bk_ca;
    logic [NB*4-1:0]  bk_id;
    logic [NB*4-1:0]  bk_len;
    logic [NB-1:0]   act_gnt, rd_gnt, wr_gnt, pre_gnt;
    logic            ref_gnt;
    logic            cmd_valid;
    logic [2:0]      cmd_type;
    logic [1:0]      cmd_ba;
    logic [15:0]     cmd_ra;
    logic [9:0]      cmd_ca;
    logic [3:0]      cmd_id;
    logic [3:0]      cmd_len;

    sal_cmd_sched dut (
        .clk(clk), .rst_n(rst_n),
        .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
        .bk_ra(bk_ra), .bk_ca(bk_ca), .bk_id(bk_id), .bk_len(bk_len),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
        .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  typ;
        logic [1:0]  ba;
        logic [15:0] ra;
        logic [9:0]  ca;
        logic [3:0]  id;
        logic [3:0]  len;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t bank_fields(input int b, input logic [2:0] typ);
        exp_t e;
        e.typ = typ;
        e.ba  = 2'(b);
        e.ra  = 16'hA000 + 16'(b);
        e.ca  = 10'h100 + 10'(b);
        e.id  = 4'(b + 4);
        e.len = 4'(b + 8);
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.typ = 3'd0; e.ba = '0; e.ra = '0; e.ca = '0; e.id = '0; e.len = '0;
        return e;
    endfunction

    // kind: 0 none, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
    task automatic step(input string tag, input int kind, input int bank);
        logic [3:0] oh;
        exp_t e, nxt;
        oh = (kind >= 1 && kind <= 4) ? 4'(1 << bank) : 4'b0;
        @(negedge clk);
        check({tag, ".act_gnt"}, 32'(act_gnt), (kind == 1) ? 32'(oh) : 32'd0);
        check({tag, ".rd_gnt"},  32'(rd_gnt),  (kind == 2) ? 32'(oh) : 32'd0);
        check({tag, ".wr_gnt"},  32'(wr_gnt),  (kind == 3) ? 32'(oh) : 32'd0);
        check({tag, ".pre_gnt"}, 32'(pre_gnt), (kind == 4) ? 32'(oh) : 32'd0);
        check({tag, ".ref_gnt"}, 32'(ref_gnt), (kind == 5) ? 32'd1 : 32'd0);
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ".cmd_valid"}, 32'(cmd_valid), (e.typ != 3'd0) ? 32'd1 : 32'd0);
            check({tag, ".cmd_type"},  32'(cmd_type), 32'(e.typ));
            check({tag, ".cmd_ba"},    32'(cmd_ba),   32'(e.ba));
            check({tag, ".cmd_ra"},    32'(cmd_ra),   32'(e.ra));
            check({tag, ".cmd_ca"},    32'(cmd_ca),   32'(e.ca));
            check({tag, ".cmd_id"},    32'(cmd_id),   32'(e.id));
            check({tag, ".cmd_len"},   32'(cmd_len),  32'(e.len));
        end
        if (kind >= 1 && kind <= 4) begin
            held = bank_fields(bank, 3'(kind));
            nxt  = held;
        end else begin
            nxt     = held;
            nxt.typ = (kind == 5) ? 3'd5 : 3'd0;
        end
        sb.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic sb_restart();
        sb.delete();
        held = zero_exp();
        sb.push_back(held);
    endtask

    task automatic do_reset();
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_restart();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin
        t_rrd_m1 = '0; t_ccd_m1 = '0; t_wtr_m1 = '0; t_rtw_m1 = '0;
        for (int b = 0; b < NB; b++) begin
            bk_ra[b*16 +: 16] = 16'hA000 + 16'(b);
            bk_ca[b*10 +: 10] = 10'h100 + 10'(b);
            bk_id[b*4 +: 4]   = 4'(b + 4);
            bk_len[b*4 +: 4]  = 4'(b + 8);
        end
        do_reset();

        // tRRD spacing: second ACT three cycles after the first
        t_rrd_m1 = 4'd2;
        act_req = 4'b0011;
        step("t1_act0", 1, 0);
        act_req = 4'b0010;
        step("t1_wait1", 0, 0);
        step("t1_wait2", 0, 0);
        step("t1_act1", 1, 1);
        act_req = 4'b0000;
        step("t1_idle", 0, 0);

        // tCCD: held RD pulses every four cycles
        t_ccd_m1 = 4'd3;
        rd_req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step("t2_rd0", 2, 0);
            if (k == 2) rd_req = 4'b0000;
            repeat (3) step("t2_gap", 0, 0);
        end

        // tWTR blocks RD; ACT slips in meanwhile
        t_wtr_m1 = 4'd5;
        t_ccd_m1 = 4'd1;
        wr_req = 4'b0001;
        step("t3_wr0", 3, 0);
        wr_req = 4'b0000;
        rd_req = 4'b0010;
        act_req = 4'b0100;
        step("t3_act2", 1, 2);
        act_req = 4'b0000;
        repeat (4) step("t3_wtr", 0, 0);
        step("t3_rd1", 2, 1);
        rd_req = 4'b0000;
        step("t3_idle", 0, 0);

        // Class priority REF > column > ACT, ACT round-robin
        t_rrd_m1 = '0; t_ccd_m1 = '0; t_wtr_m1 = '0; t_rtw_m1 = '0;
        do_reset();
        ref_req = 1'b1;
        act_req = 4'b1111;
        rd_req  = 4'b0001;
        step("t4_ref", 5, 0);
        ref_req = 1'b0;
        step("t4_rd0", 2, 0);
        rd_req = 4'b0000;
        for (int b = 0; b < NB; b++) begin
            step("t4_act_rr", 1, b);
            act_req[b] = 1'b0;
        end
        step("t4_idle", 0, 0);

        // Column direction choice after a WR with pointer at 0
        do_reset();
        wr_req = 4'b1000;
        step("t5_wr3", 3, 3);
        wr_req  = 4'b0010;
        rd_req  = 4'b0001;
        pre_req = 4'b0100;
`ifdef SCHED_RW_AFFINITY_EN
        step("t5_aff_wr1", 3, 1);
        wr_req = 4'b0000;
        step("t5_aff_rd0", 2, 0);
        rd_req = 4'b0000;
`else
        step("t5_rr_rd0", 2, 0);
        rd_req = 4'b0000;
        step("t5_rr_wr1", 3, 1);
        wr_req = 4'b0000;
`endif
        step("t5_pre2", 4, 2);
        pre_req = 4'b0000;
        step("t5_idle", 0, 0);

        // Asynchronous reset mid-operation, then fresh arbitration
        do_reset();
        t_rrd_m1 = 4'd3;
        act_req = 4'b0101;
        step("t6_act0", 1, 0);
        act_req = 4'b0100;
        check("t6_pre_rst_valid", 32'(cmd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(cmd_valid), 32'd0);
        check("t6_rst_type",  32'(cmd_type),  32'd0);
        check("t6_rst_ba",    32'(cmd_ba),    32'd0);
        check("t6_rst_ra",    32'(cmd_ra),    32'd0);
        act_req = 4'b0101;
        #1;
        rst_n = 1'b1;
        sb_restart();
        step("t6_act0_fresh", 1, 0);
        act_req = 4'b0100;
        pre_req = 4'b0010;
        step("t6_pre1_blocked_act", 4, 1);
        pre_req = 4'b0000;
        step("t6_rrd2", 0, 0);
        step("t6_rrd1", 0, 0);
        step("t6_act2", 1, 2);
        act_req = 4'b0000;
        step("t6_idle", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
